ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//  Instruction prefetch unit between instruction memory and the core's IF/ID stage.
//  Issues in-order word fetches on a req/gnt/rvalid bus and tags each word with its PC.
//  Buffers up to DEPTH instructions in a small queue and presents them to IF/ID
//  over a valid/ready handshake.
//  A flush redirects fetch to a new PC; responses already in flight on the bus are discarded.
// PARAMETERS
//  DEPTH     4             queue slots incl. in-flight reservations; power of 2, >=2
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk           in   1   core clock
//  rst           in   1   synchronous reset, active-high
//  flush_i       in   1   redirect request (branch/jump taken)
//  flush_pc_i    in   32  redirect target; bits[1:0] ignored (forced 0)
//  mem_req_o     out  1   fetch request
//  mem_addr_o    out  32  fetch word address, valid while mem_req_o
//  mem_gnt_i     in   1   request accepted this cycle (req&gnt = issue)
//  mem_rvalid_i  in   1   read data valid; responses in issue order, >=1 cycle after gnt
//  mem_rdata_i   in   32  read data
//  inst_valid_o  out  1   head instruction available
//  inst_o        out  32  head instruction; `ZeroWord when !inst_valid_o
//  inst_pc_o     out  32  PC of head instruction; `ZeroWord when !inst_valid_o
//  inst_ready_i  in   1   IF/ID accepts head (valid&ready = pop)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset: fetch_pc=RESET_PC, queue empty, drop_cnt=0; mem_req_o=0, inst_valid_o=0, inst_o=inst_pc_o=0.
//  State: fetch_pc (32b); slot array {pc,data,filled}; pointers head/fill/tail; used=tail-head;
//    drop_cnt = stale responses still owed by bus. Counters are clog2(DEPTH)+1 bits.
//  Issue: mem_req_o = !rst & !flush_i & (used+drop_cnt < DEPTH); mem_addr_o = fetch_pc.
//    - On req&gnt: reserve slot at tail with pc=fetch_pc, filled=0; fetch_pc += 4 (wraps mod 2^32).
//    - Bus allows withdrawal: req may drop or the address may change before gnt.
//  Response: on rvalid, if drop_cnt>0 then drop_cnt-1 and data discarded.
//    Otherwise write data to the slot at fill and set filled; fill+1.
//    rvalid with no owed response is a bus error: ignored, covered by an assertion.
//  Output: inst_valid_o = slot[head].filled & !flush_i (registered state, gated combinationally).
//    Pop on valid&ready: head+1.
//  Latency: gnt in cycle N, rvalid in N+1 -> inst_valid_o in N+2. Sustains 1 instr/cycle when DEPTH>=3.
//  Flush (cycle F):
//    - all slots cleared; head=fill=tail; fetch_pc <= {flush_pc_i[31:2],2'b00}.
//    - drop_cnt <= (reserved-unfilled slots) + drop_cnt - (rvalid_F ? 1:0).
//    - no issue in cycle F (mem_req_o=0), so gnt_F cannot occur.
//    - any pop in F is ignored. First request to the new PC goes out in F+1.
//  Simultaneous events:
//    - pop+rvalid+gnt in one cycle is all applied; used is unchanged net.
//    - rvalid into the head slot makes it valid the next cycle; no same-cycle bypass.
//  Full: used+drop_cnt==DEPTH holds mem_req_o low. An empty queue just holds inst_valid_o low.
//  Reset mid-operation overrides flush and all handshakes. After reset the bus must not deliver
//    stale rvalid; the SoC guarantees this by resetting memory with the core.
// STRUCTURE
//  bitty_defs.v (shared): `InstAddrBus, `InstBus, `ZeroWord, `RstEnable; add `PcStep (32'd4).
//  Sub-module prefetch_fifo holds slot storage and the head/fill/tail pointers.
//    Ports: reserve(pc), fill(data), pop, clear. It exposes head entry, used count and filled flag.
//  ifu_prefetch holds fetch_pc, drop_cnt, the issue logic and the flush sequencing.
//  The core top replaces the pc_reg and rom_* path with this block; IF/ID gains a stall on !inst_valid_o.
// TESTING
//  1 Reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1:
//    addrs 0,4,8... issued back-to-back; inst_valid_o from cycle 2; inst_pc_o 0,4,8 with matching data.
//  2 ready=0 with zero-latency gnt:
//    exactly DEPTH(4) issues, then mem_req_o low; ready=1 drains 4 in order; fetching resumes.
//  3 Flush to 32'h0000_0103 with 2 responses in flight:
//    next two rvalid dropped; next issued addr 32'h100; first output pc 32'h100.
//  4 Flush in the same cycle as rvalid, with 1 other outstanding:
//    drop_cnt=1; exactly one later rvalid dropped; no old-PC instruction appears.
//  5 Random gnt/rvalid delays (0-3 cycles) and random ready, 1000 instrs:
//    output PC sequence contiguous, data == mem[pc]; no loss or duplication.
//  6 rst asserted with a full queue and outstanding requests:
//    next cycle inst_valid_o=0, mem_req_o=0; after release first addr = RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_pkg
// Description : Shared types and constants for the instruction prefetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_prefetch_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_t      c_zero_word = 32'h0000_0000;
    localparam inst_addr_t c_pc_step   = 32'd4;

    // One queue entry as seen at the head of the queue
    typedef struct packed {
        inst_addr_t pc;
        inst_t      data;
    } slot_t;

    // Word-align a fetch address (low two bits forced to zero)
    function automatic inst_addr_t align_word(input inst_addr_t a);
        return a & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_if
// Description : Instruction-memory bus (req/gnt/rvalid) plus the IF/ID
//               valid/ready handshake of the prefetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_prefetch_if;
    import ifu_prefetch_pkg::*;

    // memory side
    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_gnt_i;
    logic       mem_rvalid_i;
    inst_t      mem_rdata_i;

    // IF/ID side
    logic       inst_valid_o;
    inst_t      inst_o;
    inst_addr_t inst_pc_o;
    logic       inst_ready_i;

    // the prefetch unit
    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
    );

    // memory and IF/ID stage together
    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/ifu_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_fifo
// Description : Slot storage for the prefetch queue. Slots are reserved at
//               tail on issue, filled in order at fill on response and popped
//               at head. Pointers carry one extra wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          reserve_i,
    input  inst_addr_t    reserve_pc_i,
    input  logic          fill_i,
    input  inst_t         fill_data_i,
    input  logic          pop_i,
    output logic          head_filled_o,
    output slot_t         head_o,
    output logic [CW-1:0] used_o,
    output logic [CW-1:0] unfilled_o
);

    inst_addr_t       pc_q   [DEPTH];
    inst_t            data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [CW-1:0]    head_q;
    logic [CW-1:0]    fill_q;
    logic [CW-1:0]    tail_q;

    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_fill_idx;
    logic [AW-1:0]    w_tail_idx;

    assign w_head_idx = head_q[AW-1:0];
    assign w_fill_idx = fill_q[AW-1:0];
    assign w_tail_idx = tail_q[AW-1:0];

    // Pointers and filled flags; clear drops every slot at once. The three
    // flag updates always hit distinct slots while the queue is used legally.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
        end else begin
            if (reserve_i) begin
                filled_q[w_tail_idx] <= 1'b0;
                tail_q               <= tail_q + CW'(1);
            end
            if (fill_i) begin
                filled_q[w_fill_idx] <= 1'b1;
                fill_q               <= fill_q + CW'(1);
            end
            if (pop_i) begin
                filled_q[w_head_idx] <= 1'b0;
                head_q               <= head_q + CW'(1);
            end
        end
    end

    // Payload storage needs no reset: a slot is only read once it is filled.
    always_ff @(posedge clk) begin
        if (reserve_i) begin
            pc_q[w_tail_idx] <= reserve_pc_i;
        end
        if (fill_i) begin
            data_q[w_fill_idx] <= fill_data_i;
        end
    end

    assign head_filled_o = filled_q[w_head_idx];
    assign head_o        = {pc_q[w_head_idx], data_q[w_head_idx]};
    assign used_o        = tail_q - head_q;
    assign unfilled_o    = tail_q - fill_q;

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction prefetch unit. Issues in-order word fetches,
//               buffers up to DEPTH instructions tagged with their PC and
//               hands them to IF/ID. A flush redirects fetch and discards the
//               responses still owed by the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter inst_addr_t RESET_PC = 32'h0000_0000
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  inst_addr_t    flush_pc_i,
    ifu_prefetch_if.master bus
);

    localparam int           CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]  c_depth = (CW+1)'(DEPTH);

    inst_addr_t    fetch_pc_q;
    inst_addr_t    fetch_pc_d;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] drop_cnt_d;

    logic          w_head_filled;
    slot_t         w_head;
    logic [CW-1:0] w_used;
    logic [CW-1:0] w_unfilled;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_issue;
    logic          w_resp_drop;
    logic          w_resp_fill;
    logic          w_valid;
    logic          w_pop;

    // Stale responses also hold a slot's worth of credit until they arrive,
    // so they count against the queue limit.
    assign w_occupancy = {1'b0, w_used} + {1'b0, drop_cnt_q};
    assign w_req       = !rst && !flush_i && (w_occupancy < c_depth);
    assign w_issue     = w_req && bus.mem_gnt_i;

    // A response with nothing owed is ignored entirely.
    assign w_resp_drop = bus.mem_rvalid_i && (drop_cnt_q != '0);
    assign w_resp_fill = bus.mem_rvalid_i && (drop_cnt_q == '0) && (w_unfilled != '0);

    assign w_valid     = w_head_filled && !flush_i;
    assign w_pop       = w_valid && bus.inst_ready_i;

    ifu_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (flush_i),
        .reserve_i     (w_issue),
        .reserve_pc_i  (fetch_pc_q),
        .fill_i        (w_resp_fill),
        .fill_data_i   (bus.mem_rdata_i),
        .pop_i         (w_pop),
        .head_filled_o (w_head_filled),
        .head_o        (w_head),
        .used_o        (w_used),
        .unfilled_o    (w_unfilled)
    );

    // Next fetch PC and stale-response count. On flush every reserved but
    // unfilled slot turns into a response to discard, less the one (if any)
    // consumed in the flush cycle itself.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            fetch_pc_d = align_word(flush_pc_i);
            drop_cnt_d = w_unfilled + drop_cnt_q - CW'(w_resp_drop || w_resp_fill);
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + c_pc_step;
            end
            if (w_resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.mem_req_o    = w_req;
    assign bus.mem_addr_o   = fetch_pc_q;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? w_head.data : c_zero_word;
    assign bus.inst_pc_o    = w_valid ? w_head.pc   : c_zero_word;

    // The bus must never return data that was not requested.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid_i |-> ((drop_cnt_q != '0) || (w_unfilled != '0)));

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Directed and randomised bench for ifu_prefetch with an
//               in-order memory model and a PC/data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int         DEPTH    = 4;
    localparam inst_addr_t RESET_PC = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_i = 1'b0;
    inst_addr_t flush_pc_i = '0;

    ifu_prefetch_if bus();

    ifu_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_pops = 0;
    bit          gnt_rand = 0;
    bit          ready_rand = 0;
    bit          hold_rv = 0;
    int          rv_extra_max = 0;
    logic        ready_val = 1'b1;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    bit          s_issue, s_pop;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, want);
    endtask

    // One clock: drive inputs at negedge, sample #1 later, update model.
    task automatic do_cycle(input bit f, input logic [31:0] fpc, input bit r);
        pend_t p;
        @(negedge clk);
        rst              = r;
        flush_i          = f;
        flush_pc_i       = fpc;
        bus.mem_gnt_i    = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.inst_ready_i = ready_rand ? ($urandom_range(0, 1) == 1) : ready_val;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        if (r) begin
            pend.delete();
        end else if (!hold_rv && pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = mem_word(p.addr);
        end
        #1;
        s_req   = bus.mem_req_o;
        s_addr  = bus.mem_addr_o;
        s_valid = bus.inst_valid_o;
        s_pc    = bus.inst_pc_o;
        s_inst  = bus.inst_o;
        s_issue = s_req && bus.mem_gnt_i;
        if (s_issue) begin
            p.addr = s_addr;
            p.due  = cyc + 1 + $urandom_range(0, rv_extra_max);
            pend.push_back(p);
        end
        s_pop = s_valid && bus.inst_ready_i && !r;
        if (r) begin
            exp_pc = RESET_PC;
        end else if (f) begin
            exp_pc = {fpc[31:2], 2'b00};
        end else if (s_pop) begin
            check("sb_pc", s_pc, exp_pc);
            check("sb_inst", s_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        gnt_rand = 0; ready_rand = 0; hold_rv = 0; rv_extra_max = 0; ready_val = 1'b1;
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        int          issues;
        bit          got;
        logic [31:0] first_addr;
        int          k;

        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = '0; bus.inst_ready_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_req",   32'(s_req), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_inst",  s_inst, 32'h0);
        check("rst_pc",    s_pc, 32'h0);

        // T1: back-to-back issue, one-cycle response, always ready
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            check("t1_req",  32'(s_req), 32'd1);
            check("t1_addr", s_addr, 32'(4 * i));
            if (i >= 2) begin
                check("t1_valid", 32'(s_valid), 32'd1);
                check("t1_pc",    s_pc, 32'(4 * (i - 2)));
            end else begin
                check("t1_valid", 32'(s_valid), 32'd0);
            end
        end

        // T2: ready low fills the queue, then drain and resume
        do_reset();
        ready_val = 1'b0;
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            if (s_issue) issues++;
        end
        check("t2_issues",   32'(issues), 32'd4);
        check("t2_req_held", 32'(s_req), 32'd0);
        ready_val = 1'b1;
        got = 0; first_addr = '0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            check("t2_valid", 32'(s_valid), 32'd1);
            check("t2_pc",    s_pc, 32'(4 * i));
            if (s_issue && !got) begin got = 1; first_addr = s_addr; end
        end
        for (int i = 0; i < 10 && !got; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            if (s_issue) begin got = 1; first_addr = s_addr; end
        end
        check("t2_resumed",     32'(got), 32'd1);
        check("t2_resume_addr", first_addr, 32'h10);

        // T3: flush with two responses in flight
        do_reset();
        hold_rv = 1;
        do_cycle(1'b0, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b0);
        do_cycle(1'b1, 32'h0000_0103, 1'b0);
        check("t3_flush_req", 32'(s_req), 32'd0);
        hold_rv = 0;
        do_cycle(1'b0, '0, 1'b0);
        check("t3_req",  32'(s_req), 32'd1);
        check("t3_addr", s_addr, 32'h100);
        k = 0;
        while (!s_valid && k < 20) begin do_cycle(1'b0, '0, 1'b0); k++; end
        check("t3_valid_seen", 32'(s_valid), 32'd1);
        check("t3_first_pc",   s_pc, 32'h100);
        check("t3_first_inst", s_inst, 32'hC0DE_0100);
        repeat (6) do_cycle(1'b0, '0, 1'b0);

        // T4: flush coincides with a response, one more still owed
        do_reset();
        hold_rv = 1;
        do_cycle(1'b0, '0, 1'b0);
        do_cycle(1'b0, '0, 1'b0);
        hold_rv = 0;
        do_cycle(1'b1, 32'h0000_0200, 1'b0);
        check("t4_flush_req", 32'(s_req), 32'd0);
        check("t4_flush_rv",  32'(bus.mem_rvalid_i), 32'd1);
        k = 0;
        do_cycle(1'b0, '0, 1'b0);
        while (!s_valid && k < 20) begin do_cycle(1'b0, '0, 1'b0); k++; end
        check("t4_valid_seen", 32'(s_valid), 32'd1);
        check("t4_first_pc",   s_pc, 32'h200);
        check("t4_first_inst", s_inst, 32'hC0DE_0200);
        repeat (6) do_cycle(1'b0, '0, 1'b0);

        // T5: random grant/response latency, random ready, sparse flushes
        do_reset();
        gnt_rand = 1; ready_rand = 1; rv_extra_max = 3;
        n_pops = 0;
        k = 0;
        while (n_pops < 1000 && k < 20000) begin
            if ($urandom_range(0, 99) == 0)
                do_cycle(1'b1, 32'($urandom_range(0, 16'hFFFF)), 1'b0);
            else
                do_cycle(1'b0, '0, 1'b0);
            k++;
        end
        check("t5_pops", 32'(n_pops >= 1000), 32'd1);

        // T6: reset with a full queue and requests outstanding
        do_reset();
        ready_val = 1'b0;
        repeat (3) do_cycle(1'b0, '0, 1'b0);
        hold_rv = 1;
        repeat (2) do_cycle(1'b0, '0, 1'b0);
        check("t6_full_req",   32'(s_req), 32'd0);
        check("t6_full_valid", 32'(s_valid), 32'd1);
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b1);
        check("t6_valid", 32'(s_valid), 32'd0);
        check("t6_req",   32'(s_req), 32'd0);
        check("t6_inst",  s_inst, 32'h0);
        check("t6_pc",    s_pc, 32'h0);
        hold_rv = 0; ready_val = 1'b1;
        do_cycle(1'b0, '0, 1'b0);
        check("t6_req_after",  32'(s_req), 32'd1);
        check("t6_addr_after", s_addr, RESET_PC);
        n_pops = 0;
        repeat (6) do_cycle(1'b0, '0, 1'b0);
        check("t6_pops", 32'(n_pops > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
